// File: rtl/shift_rotate_sequencer_pkg.sv
// Shared definitions for the shift/rotate sequencer: widths, opcodes,
// FSM state encoding and an opcode legality helper.
package shift_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int AMT_W_DEF  = 3;

    localparam logic [2:0] OP_SRA = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SLA = 3'd2;
    localparam logic [2:0] OP_SLL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;
    localparam logic [2:0] OP_ROL = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Opcodes 110 and 111 have no step behaviour and yield a zero result.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_ROL);
    endfunction

endpackage

// File: rtl/shift_rotate_sequencer_if.sv
// Request/result handshake bundle between the ALU controller (master)
// and the shift/rotate sequencer (slave).
interface shift_rotate_sequencer_if
    import shift_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AMT_W  = AMT_W_DEF
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [2:0]        in_opcode;
    logic [AMT_W-1:0]  in_amount;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output in_opcode,
        output in_amount,
        input  out_valid,
        output out_ready,
        input  out_data
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  in_opcode,
        input  in_amount,
        output out_valid,
        input  out_ready,
        output out_data
    );

endinterface

// File: rtl/shift_rotate_sequencer_step.sv
// Purely combinational single-bit shift/rotate step, shared by every
// iteration of the sequencer.
module shift_rotate_step
    import shift_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [2:0]        opcode_i,
    output logic [DATA_W-1:0] data_o
);

    // One-position move of the operand; illegal opcodes collapse to zero.
    always_comb begin
        data_o = '0;
        case (opcode_i)
            OP_SRA:  data_o = {data_i[DATA_W-1], data_i[DATA_W-1:1]};
            OP_SRL:  data_o = {1'b0, data_i[DATA_W-1:1]};
            OP_SLA:  data_o = {data_i[DATA_W-2:0], 1'b0};
            OP_SLL:  data_o = {data_i[DATA_W-2:0], 1'b0};
            OP_ROR:  data_o = {data_i[0], data_i[DATA_W-1:1]};
            OP_ROL:  data_o = {data_i[DATA_W-2:0], data_i[DATA_W-1]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/shift_rotate_sequencer.sv
// Multi-cycle sequencer turning the 1-bit shift/rotate step into an
// N-bit shifter: accepts a request, iterates the step `amount` times,
// then holds the result until the consumer takes it.
module shift_rotate_sequencer
    import shift_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AMT_W  = AMT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    shift_rotate_sequencer_if.slave  bus,
    output logic                     busy_o
);

    state_e            state_q;
    logic [DATA_W-1:0] data_q;
    logic [2:0]        opcode_q;
    logic [AMT_W-1:0]  cnt_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;
    logic [DATA_W-1:0] stepped_d;

    shift_rotate_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .data_i   (data_q),
        .opcode_i (opcode_q),
        .data_o   (stepped_d)
    );

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            opcode_q    <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        opcode_q   <= bus.in_opcode;
                        cnt_q      <= bus.in_amount;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (!op_is_legal(bus.in_opcode)) begin
                            data_q      <= '0;
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end else if (bus.in_amount == '0) begin
                            data_q      <= bus.in_data;
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            data_q  <= bus.in_data;
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_q <= stepped_d;
                    cnt_q  <= cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_valid_q && bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_shift_rotate_sequencer.sv
// Self-checking bench for shift_rotate_sequencer: directed cases with
// literal results, a mid-operation reset, backpressure, and a randomized
// run compared every cycle against a transaction-level model.
module tb_shift_rotate_sequencer;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    int checks = 0;
    int errors = 0;

    shift_rotate_sequencer_if bus_if ();

    shift_rotate_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus_if),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Result of shifting/rotating d by n positions, computed in one go.
    function automatic logic [7:0] golden(input logic [7:0] d, input logic [2:0] op, input int n);
        logic signed [7:0] s;
        logic [15:0] w;
        golden = 8'h00;
        s = d;
        w = {d, d};
        case (op)
            OP_SRA: begin s = s >>> n; golden = s; end
            OP_SRL: golden = d >> n;
            OP_SLA: golden = d << n;
            OP_SLL: golden = d << n;
            OP_ROR: begin w = w >> (n % 8); golden = w[7:0]; end
            OP_ROL: begin w = w << (n % 8); golden = w[15:8]; end
            default: golden = 8'h00;
        endcase
    endfunction

    // Transaction-level model: one pending request, edges elapsed since accept.
    bit         mPend;
    int         mElapsed;
    int         mLat;
    logic [7:0] mDin;
    logic [2:0] mOp;
    int         mAmt;
    bit         mIll;
    logic [7:0] mLast;

    initial begin
        logic       expValid;
        logic [7:0] expData;
        int         steps;
        mPend = 0; mElapsed = 0; mLat = 0; mDin = 0; mOp = 0; mAmt = 0; mIll = 0; mLast = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mPend = 0;
                mLast = 8'h00;
                checkOutput("cmp_rst_in_ready", bus_if.in_ready, 1);
                checkOutput("cmp_rst_out_valid", bus_if.out_valid, 0);
                checkOutput("cmp_rst_out_data", bus_if.out_data, 8'h00);
                checkOutput("cmp_rst_busy", busy, 0);
            end else begin
                steps    = (mElapsed < mAmt) ? mElapsed : mAmt;
                expValid = mPend && (mElapsed >= mLat);
                expData  = !mPend ? mLast : (mIll ? 8'h00 : golden(mDin, mOp, steps));
                checkOutput("cmp_in_ready", bus_if.in_ready, !mPend);
                checkOutput("cmp_busy", busy, mPend);
                checkOutput("cmp_out_valid", bus_if.out_valid, expValid);
                checkOutput("cmp_out_data", bus_if.out_data, expData);
                if (mPend) begin
                    if (expValid && bus_if.out_ready) begin
                        mPend = 0;
                        mLast = expData;
                    end else if (!expValid) begin
                        mElapsed++;
                    end
                end else if (bus_if.in_valid) begin
                    mPend    = 1;
                    mElapsed = 0;
                    mDin     = bus_if.in_data;
                    mOp      = bus_if.in_opcode;
                    mAmt     = int'(bus_if.in_amount);
                    mIll     = (bus_if.in_opcode > 3'd5);
                    mLat     = (mIll || mAmt == 0) ? 0 : mAmt;
                end
            end
        end
    end

    // Waits for out_valid after the accept edge and checks latency and data.
    task automatic checkResult(input string name, input logic [7:0] expData, input int expLat);
        int lat;
        lat = 0;
        while (!bus_if.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({name, "_latency"}, lat, expLat);
        checkOutput({name, "_data"}, bus_if.out_data, expData);
    endtask

    // Presents one request, waits for it to be accepted, then checks the result.
    task automatic applyStimulus(input string name, input logic [7:0] d, input logic [2:0] op,
                                 input logic [2:0] amt, input logic [7:0] expData, input int expLat,
                                 input bit consume);
        int n;
        @(posedge clk); #1;
        bus_if.in_valid  = 1'b1;
        bus_if.in_data   = d;
        bus_if.in_opcode = op;
        bus_if.in_amount = amt;
        bus_if.out_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus_if.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checkOutput({name, "_accept_timeout"}, 0, 1);
            bus_if.in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            bus_if.in_valid  = 1'b0;
            bus_if.in_data   = 8'($urandom);
            bus_if.in_opcode = 3'($urandom);
            bus_if.in_amount = 3'($urandom);
            checkResult(name, expData, expLat);
            if (consume) begin
                bus_if.out_ready = 1'b1;
                @(posedge clk); #1;
                bus_if.out_ready = 1'b0;
                checkOutput({name, "_idle_after"}, bus_if.in_ready, 1);
                checkOutput({name, "_keep_last"}, bus_if.out_data, expData);
            end
        end
    endtask

    initial begin
        int sent;
        int cyc;
        bit acc;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = 8'h00;
        bus_if.in_opcode = 3'd0;
        bus_if.in_amount = 3'd0;
        bus_if.out_ready = 1'b0;
        rst_n = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", bus_if.in_ready, 1);
        checkOutput("reset_out_valid", bus_if.out_valid, 0);
        checkOutput("reset_out_data", bus_if.out_data, 8'h00);
        checkOutput("reset_busy", busy, 0);
        rst_n = 1'b1;

        checkOutput("model_sra_1", golden(8'h96, OP_SRA, 1), 8'hCB);
        checkOutput("model_sra_2", golden(8'h96, OP_SRA, 2), 8'hE5);
        checkOutput("model_sra_3", golden(8'h96, OP_SRA, 3), 8'hF2);
        checkOutput("model_rol_7", golden(8'h81, OP_ROL, 7), 8'hC0);
        checkOutput("model_ror_1", golden(8'h81, OP_ROR, 1), 8'hC0);
        checkOutput("model_sll_2", golden(8'h01, OP_SLL, 2), 8'h04);

        applyStimulus("sra3", 8'h96, OP_SRA, 3'd3, 8'hF2, 3, 1);
        applyStimulus("rol7", 8'h81, OP_ROL, 3'd7, 8'hC0, 7, 1);
        applyStimulus("ror1", 8'h81, OP_ROR, 3'd1, 8'hC0, 1, 1);
        applyStimulus("srl0", 8'h5A, OP_SRL, 3'd0, 8'h5A, 0, 1);
        applyStimulus("illegal", 8'hFF, 3'b111, 3'd5, 8'h00, 0, 1);

        // Backpressure: result held for 4 cycles while a second request waits.
        applyStimulus("bp_first", 8'hA5, OP_SLA, 3'd1, 8'h4A, 1, 0);
        bus_if.in_valid  = 1'b1;
        bus_if.in_data   = 8'h01;
        bus_if.in_opcode = OP_SLL;
        bus_if.in_amount = 3'd2;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_data_stable", bus_if.out_data, 8'h4A);
            checkOutput("bp_out_valid", bus_if.out_valid, 1);
            checkOutput("bp_in_ready", bus_if.in_ready, 0);
        end
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        checkOutput("bp_reenter_idle", bus_if.in_ready, 1);
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        checkOutput("bp_second_accepted", busy, 1);
        checkResult("bp_second", 8'h04, 2);
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;

        // Reset pulled low in the middle of a shift sequence.
        applyStimulus("pre_reset", 8'h96, OP_SRA, 3'd7, 8'hFF, 7, 0);
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.in_data   = 8'h3C;
        bus_if.in_opcode = OP_ROL;
        bus_if.in_amount = 3'd6;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("mid_shift_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_in_ready", bus_if.in_ready, 1);
        checkOutput("async_rst_out_valid", bus_if.out_valid, 0);
        checkOutput("async_rst_out_data", bus_if.out_data, 8'h00);
        checkOutput("async_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomized traffic with random consumer stalls.
        sent = 0;
        cyc = 0;
        while (sent < 200 && cyc < 20000) begin
            @(negedge clk);
            acc = bus_if.in_valid && bus_if.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                bus_if.in_valid = 1'b0;
            end
            bus_if.out_ready = 1'($urandom_range(0, 1));
            if (!bus_if.in_valid) begin
                bus_if.in_data   = 8'($urandom);
                bus_if.in_opcode = 3'($urandom_range(0, 7));
                bus_if.in_amount = 3'($urandom_range(0, 7));
                if (sent < 200 && $urandom_range(0, 3) != 0) bus_if.in_valid = 1'b1;
            end
        end
        checkOutput("random_requests_sent", sent, 200);
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("final_idle", bus_if.in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
